// File: rtl/pipelined_accumulate_engine.sv
// -----------------------------------------------------------------------------
// pipelined_accumulate_engine
//
// Walks an external, combinationally read memory from word 0 to LENGTH-1.
// Each word passes through a DEPTH-stage valid-tagged pipeline into a
// WIDTH-bit accumulator that adds or subtracts, depending on the mode latched
// at start. A sticky flag records any signed overflow during the run.
// A global enable freezes every register, including the FSM.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-low; clears all state
//   start   in   begin a run (accepted in IDLE or DONE while enable=1)
//   mode    in   0 = add, 1 = subtract; latched when start is accepted
//   enable  in   global advance; 0 holds all state
//   addr    out  [ADDR_W] memory word index
//   data    in   [WIDTH]  memory read data for addr, same cycle
//   out     out  [WIDTH]  accumulator value
//   busy    out  high in RUN or DRAIN
//   done    out  high in DONE
//   ovf     out  sticky signed overflow for the current run
// -----------------------------------------------------------------------------
module pipelined_accumulate_engine #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 30,
   parameter int DEPTH  = 1,
   parameter int LENGTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic              enable,
   output logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  data,
   output logic [WIDTH-1:0]  out,
   output logic              busy,
   output logic              done,
   output logic              ovf
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LENGTH - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ADDR_W-1:0]  r_idx;
   logic [WIDTH-1:0]   r_acc;
   logic               r_ovf;
   logic               r_mode;
   logic [WIDTH-1:0]   r_pipe_d [DEPTH];
   logic [DEPTH-1:0]   r_pipe_v;

   logic               w_start_ok;
   logic               w_tail_clear;
   logic [WIDTH-1:0]   w_d;
   logic [WIDTH-1:0]   w_res;

   // Signed overflow of acc (+/-) d giving res, judged from sign bits only.
   function automatic logic f_ovf(input logic             sub,
                                  input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic [WIDTH-1:0] r);
      logic sa, sb, sr;
      sa = a[WIDTH-1];
      sb = b[WIDTH-1];
      sr = r[WIDTH-1];
      if (sub) return (sa != sb) && (sr != sa);
      else     return (sa == sb) && (sr != sa);
   endfunction

   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_d        = r_pipe_d[DEPTH-1];
   assign w_res      = r_mode ? (r_acc - w_d) : (r_acc + w_d);

   // True when no word sits ahead of the final stage. In DRAIN no new word
   // enters, so the next edge accumulates the last word and empties the pipe.
   always_comb begin
      w_tail_clear = 1'b1;
      for (int k = 0; k < DEPTH - 1; k++) begin
         if (r_pipe_v[k]) w_tail_clear = 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (r_idx == LAST_IDX) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_tail_clear) w_state_nxt = S_DONE;
         S_DONE:  if (start) w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_acc    <= '0;
         r_ovf    <= 1'b0;
         r_mode   <= 1'b0;
         r_pipe_v <= '0;
         for (int k = 0; k < DEPTH; k++) r_pipe_d[k] <= '0;
      end else if (enable) begin
         r_state <= w_state_nxt;

         // Stage 1 samples memory every edge; only RUN tags it valid.
         r_pipe_d[0] <= data;
         r_pipe_v[0] <= (r_state == S_RUN);
         for (int k = 1; k < DEPTH; k++) begin
            r_pipe_d[k] <= r_pipe_d[k-1];
            r_pipe_v[k] <= r_pipe_v[k-1];
         end

         if (w_start_ok) begin
            r_idx  <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_mode <= mode;
         end else begin
            if ((r_state == S_RUN) && (r_idx != LAST_IDX)) r_idx <= r_idx + ADDR_W'(1);
            if (r_pipe_v[DEPTH-1]) begin
               r_acc <= w_res;
               if (f_ovf(r_mode, r_acc, w_d, w_res)) r_ovf <= 1'b1;
            end
         end
      end
   end

   assign addr = r_idx;
   assign out  = r_acc;
   assign ovf  = r_ovf;
   assign busy = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done = (r_state == S_DONE);

endmodule
